// File: rtl/scroll_load_sequencer.sv
// Scroll-counter load writer: double-buffers CPU scroll writes until vertical
// blank, then drives BD and pulses HSLDn/VSLDn to preset the scroll counters.
module scroll_load_sequencer (
  input  logic       CLK10,
  input  logic       RESET,
  input  logic       CPU_WR,
  input  logic       CPU_A,
  input  logic [7:0] CPU_D,
  input  logic       HBLANK1n,
  input  logic       VBLANK,
  input  logic       PLAYER2,
  output logic [7:0] BD,
  output logic       BD_OE,
  output logic       HSLDn,
  output logic       VSLDn,
  output logic       BUSY
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    LOAD,
    HOLD
  } state_t;

  state_t     state, next_state;
  logic       sel_v, next_sel_v;
  logic       enter_drive;
  logic [7:0] bd_q;
  logic [7:0] pend_h, pend_v;
  logic [7:0] act_h, act_v;
  logic       dirty_h, dirty_v;
  logic       req_h, req_v;
  logic       hblank1n_d, vblank_d;

  logic h_fall, v_fall, v_rise;
  logic wr_h, wr_v;
  logic eff_h, eff_v;
  logic load_h, load_v;
  logic [7:0] next_act_sel;

  assign h_fall = hblank1n_d & ~HBLANK1n;
  assign v_fall = vblank_d & ~VBLANK;
  assign v_rise = VBLANK & ~vblank_d;
  assign wr_h   = CPU_WR & ~CPU_A;
  assign wr_v   = CPU_WR & CPU_A;

  // Edges seen this cycle count as pending so a sequence can start without
  // waiting a cycle for the request flag to register.
  assign eff_h  = req_h | h_fall;
  assign eff_v  = req_v | v_fall;
  assign load_h = (state == LOAD) & ~sel_v;
  assign load_v = (state == LOAD) & sel_v;

  always_ff @(posedge CLK10 or posedge RESET) begin
    if (RESET) begin
      hblank1n_d <= 1'b1;
      vblank_d   <= 1'b0;
    end else begin
      hblank1n_d <= HBLANK1n;
      vblank_d   <= VBLANK;
    end
  end

  // A write landing on the copy edge stays pending for the next frame.
  always_ff @(posedge CLK10 or posedge RESET) begin
    if (RESET) begin
      pend_h  <= 8'h00;
      pend_v  <= 8'h00;
      act_h   <= 8'h00;
      act_v   <= 8'h00;
      dirty_h <= 1'b0;
      dirty_v <= 1'b0;
    end else begin
      if (v_rise && dirty_h) act_h <= pend_h;
      if (v_rise && dirty_v) act_v <= pend_v;
      if (wr_h) begin
        pend_h  <= CPU_D;
        dirty_h <= 1'b1;
      end else if (v_rise) begin
        dirty_h <= 1'b0;
      end
      if (wr_v) begin
        pend_v  <= CPU_D;
        dirty_v <= 1'b1;
      end else if (v_rise) begin
        dirty_v <= 1'b0;
      end
    end
  end

  // A fresh edge wins over the clear so a request is never lost.
  always_ff @(posedge CLK10 or posedge RESET) begin
    if (RESET) begin
      req_h <= 1'b0;
      req_v <= 1'b0;
    end else begin
      req_h <= h_fall | (req_h & ~load_h);
      req_v <= v_fall | (req_v & ~load_v);
    end
  end

  always_comb begin
    next_state  = state;
    next_sel_v  = sel_v;
    enter_drive = 1'b0;
    unique case (state)
      IDLE, HOLD: begin
        if (eff_v || eff_h) begin
          next_state  = DRIVE;
          next_sel_v  = eff_v;
          enter_drive = 1'b1;
        end else begin
          next_state = IDLE;
        end
      end
      DRIVE:   next_state = LOAD;
      LOAD:    next_state = HOLD;
      default: next_state = IDLE;
    endcase
  end

  assign next_act_sel = next_sel_v ? act_v : act_h;

  always_ff @(posedge CLK10 or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      sel_v <= 1'b0;
      bd_q  <= 8'h00;
    end else begin
      state <= next_state;
      sel_v <= next_sel_v;
      if (enter_drive) bd_q <= PLAYER2 ? ~next_act_sel : next_act_sel;
    end
  end

  assign BD_OE = (state != IDLE);
  assign BUSY  = BD_OE;
  assign BD    = BD_OE ? bd_q : 8'h00;
  assign HSLDn = ~load_h;
  assign VSLDn = ~load_v;

endmodule

// File: tb/tb_scroll_load_sequencer.sv
// Directed bench for scroll_load_sequencer: double buffering, flip, collision
// ordering, copy-edge writes and mid-sequence reset.
module tb_scroll_load_sequencer;

  logic       CLK10 = 1'b0;
  logic       RESET;
  logic       CPU_WR;
  logic       CPU_A;
  logic [7:0] CPU_D;
  logic       HBLANK1n;
  logic       VBLANK;
  logic       PLAYER2;
  logic [7:0] BD;
  logic       BD_OE;
  logic       HSLDn;
  logic       VSLDn;
  logic       BUSY;

  int checks = 0;
  int failures = 0;

  scroll_load_sequencer dut (
    .CLK10   (CLK10),
    .RESET   (RESET),
    .CPU_WR  (CPU_WR),
    .CPU_A   (CPU_A),
    .CPU_D   (CPU_D),
    .HBLANK1n(HBLANK1n),
    .VBLANK  (VBLANK),
    .PLAYER2 (PLAYER2),
    .BD      (BD),
    .BD_OE   (BD_OE),
    .HSLDn   (HSLDn),
    .VSLDn   (VSLDn),
    .BUSY    (BUSY)
  );

  always #5 CLK10 = ~CLK10;

  task automatic checkOutput(input string tag, input logic [7:0] actual,
                             input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%02h expected 0x%02h", tag, actual, expected);
    end
  endtask

  // Present one cycle of inputs; returns 1 time unit after the next rising edge.
  task automatic applyStimulus(input logic wr, input logic a, input logic [7:0] d,
                               input logic hb, input logic vb);
    CPU_WR   = wr;
    CPU_A    = a;
    CPU_D    = d;
    HBLANK1n = hb;
    VBLANK   = vb;
    @(posedge CLK10);
    #1;
    CPU_WR = 1'b0;
  endtask

  task automatic checkOutputs(input string tag, input logic oe, input logic [1:0] strobes,
                              input logic [7:0] bd);
    checkOutput({tag, "_oe"}, {7'd0, BD_OE}, {7'd0, oe});
    checkOutput({tag, "_busy"}, {7'd0, BUSY}, {7'd0, oe});
    checkOutput({tag, "_hv"}, {6'd0, HSLDn, VSLDn}, {6'd0, strobes});
    checkOutput({tag, "_bd"}, BD, bd);
  endtask

  // Called at n+1 after the triggering edge cycle; walks DRIVE, LOAD, HOLD, IDLE.
  task automatic checkSequence(input string tag, input logic is_v, input logic [7:0] bd);
    checkOutputs({tag, "_drive"}, 1'b1, 2'b11, bd);
    applyStimulus(1'b0, 1'b0, 8'h00, HBLANK1n, VBLANK);
    checkOutputs({tag, "_load"}, 1'b1, is_v ? 2'b10 : 2'b01, bd);
    applyStimulus(1'b0, 1'b0, 8'h00, HBLANK1n, VBLANK);
    checkOutputs({tag, "_hold"}, 1'b1, 2'b11, bd);
    applyStimulus(1'b0, 1'b0, 8'h00, HBLANK1n, VBLANK);
    checkOutputs({tag, "_idle"}, 1'b0, 2'b11, 8'h00);
  endtask

  initial begin
    RESET    = 1'b1;
    CPU_WR   = 1'b0;
    CPU_A    = 1'b0;
    CPU_D    = 8'h00;
    HBLANK1n = 1'b1;
    VBLANK   = 1'b0;
    PLAYER2  = 1'b0;
    repeat (2) @(posedge CLK10);
    #1;
    checkOutputs("reset", 1'b0, 2'b11, 8'h00);
    RESET = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    checkOutputs("post_reset", 1'b0, 2'b11, 8'h00);

    // Horizontal write made visible by a VBLANK pulse
    applyStimulus(1'b1, 1'b0, 8'h5A, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    checkSequence("vfall0", 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checkSequence("h5a", 1'b0, 8'h5A);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // Double buffering: new H value stays hidden until the next VBLANK rise
    applyStimulus(1'b1, 1'b0, 8'h10, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checkSequence("hstale", 1'b0, 8'h5A);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    checkSequence("hnew", 1'b0, 8'h10);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    // Flip: ACT_V=0x3C loaded inverted
    applyStimulus(1'b1, 1'b1, 8'h3C, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    checkSequence("vpre", 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    PLAYER2 = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    checkSequence("flip", 1'b1, 8'hC3);
    PLAYER2 = 1'b0;

    // Collision: V served first, H follows straight out of HOLD
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutputs("col_n1", 1'b1, 2'b11, 8'h3C);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutputs("col_n2", 1'b1, 2'b10, 8'h3C);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutputs("col_n3", 1'b1, 2'b11, 8'h3C);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutputs("col_n4", 1'b1, 2'b11, 8'h10);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutputs("col_n5", 1'b1, 2'b01, 8'h10);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutputs("col_n6", 1'b1, 2'b11, 8'h10);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutputs("col_n7", 1'b0, 2'b11, 8'h00);

    // CPU write on the copy edge: old pending value copies, new one next frame
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h22, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h77, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    checkSequence("copy22", 1'b1, 8'h22);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    checkSequence("copy77", 1'b1, 8'h77);

    // Reset asserted while in LOAD
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutputs("rst_drive", 1'b1, 2'b11, 8'h10);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutputs("rst_load", 1'b1, 2'b01, 8'h10);
    RESET    = 1'b1;
    HBLANK1n = 1'b1;
    #1;
    checkOutputs("rst_async", 1'b0, 2'b11, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    RESET = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    checkOutputs("rst_quiet", 1'b0, 2'b11, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checkSequence("rst_cleared", 1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
